// File: rtl/arm7tdmi_pkg.sv
// Shared ARM7TDMI types: processor modes, CPSR bit positions and exception-entry
// definitions (exception types, sequencer states, vector offsets).
package arm7tdmi_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'h10,
    MODE_FIQ = 5'h11,
    MODE_IRQ = 5'h12,
    MODE_SVC = 5'h13,
    MODE_ABT = 5'h17,
    MODE_UND = 5'h1B,
    MODE_SYS = 5'h1F
  } processor_mode_t;

  localparam int CPSR_T_BIT = 5;
  localparam int CPSR_F_BIT = 6;
  localparam int CPSR_I_BIT = 7;

  typedef enum logic [2:0] {
    EXC_NONE  = 3'd0,
    EXC_DABT  = 3'd1,
    EXC_FIQ   = 3'd2,
    EXC_IRQ   = 3'd3,
    EXC_PABT  = 3'd4,
    EXC_UNDEF = 3'd5,
    EXC_SWI   = 3'd6
  } exc_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    BRANCH = 2'd2
  } exc_state_t;

  localparam logic [31:0] VEC_UNDEF = 32'h04;
  localparam logic [31:0] VEC_SWI   = 32'h08;
  localparam logic [31:0] VEC_PABT  = 32'h0C;
  localparam logic [31:0] VEC_DABT  = 32'h10;
  localparam logic [31:0] VEC_IRQ   = 32'h18;
  localparam logic [31:0] VEC_FIQ   = 32'h1C;

  function automatic logic [4:0] exc_target_mode(input exc_type_t t);
    case (t)
      EXC_DABT, EXC_PABT: return MODE_ABT;
      EXC_FIQ:            return MODE_FIQ;
      EXC_IRQ:            return MODE_IRQ;
      EXC_UNDEF:          return MODE_UND;
      EXC_SWI:            return MODE_SVC;
      default:            return 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] exc_vec_offset(input exc_type_t t);
    case (t)
      EXC_DABT:  return VEC_DABT;
      EXC_FIQ:   return VEC_FIQ;
      EXC_IRQ:   return VEC_IRQ;
      EXC_PABT:  return VEC_PABT;
      EXC_UNDEF: return VEC_UNDEF;
      EXC_SWI:   return VEC_SWI;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/arm7tdmi_exc_prio_enc.sv
// Fixed-priority exception encoder; IRQ/FIQ are masked by the CPSR I/F bits.
module arm7tdmi_exc_prio_enc
  import arm7tdmi_pkg::*;
(
  input  logic      dabt,
  input  logic      fiq,
  input  logic      irq,
  input  logic      pabt,
  input  logic      undef,
  input  logic      swi,
  input  logic      cpsr_i,
  input  logic      cpsr_f,
  output exc_type_t winner
);

  always_comb begin
    winner = EXC_NONE;
    if (dabt)                 winner = EXC_DABT;
    else if (fiq && !cpsr_f)  winner = EXC_FIQ;
    else if (irq && !cpsr_i)  winner = EXC_IRQ;
    else if (pabt)            winner = EXC_PABT;
    else if (undef)           winner = EXC_UNDEF;
    else if (swi)             winner = EXC_SWI;
  end

endmodule

// File: rtl/arm7tdmi_exception_ctrl.sv
// Exception entry sequencer: latches sync exceptions, picks a winner at an
// instruction boundary and drives SPSR/LR writes, then CPSR/PC writes.
module arm7tdmi_exception_ctrl
  import arm7tdmi_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fiq,
  input  logic        irq,
  input  logic        data_abort,
  input  logic        prefetch_abort,
  input  logic        undef_instr,
  input  logic        swi_instr,
  input  logic        instr_boundary,
  input  logic [31:0] cpsr_in,
  input  logic [31:0] pc_in,
  output logic        exc_active,
  output logic [4:0]  exc_mode,
  output logic        spsr_we,
  output logic [31:0] spsr_wdata,
  output logic        lr_we,
  output logic [31:0] lr_wdata,
  output logic        cpsr_we,
  output logic [31:0] cpsr_wdata,
  output logic        pc_we,
  output logic [31:0] pc_wdata,
  output logic        exc_done
);

  exc_state_t  state_q, state_d;
  exc_type_t   type_q, type_d, winner;
  logic [31:0] cpsr_q, cpsr_d, pc_q, pc_d;
  logic        dabt_q, dabt_d, pabt_q, pabt_d, und_q, und_d, swi_q, swi_d;
  logic [31:0] lr_off, cpsr_new;

  arm7tdmi_exc_prio_enc u_prio (
    .dabt   (dabt_q | data_abort),
    .fiq    (fiq),
    .irq    (irq),
    .pabt   (pabt_q | prefetch_abort),
    .undef  (und_q | undef_instr),
    .swi    (swi_q | swi_instr),
    .cpsr_i (cpsr_in[CPSR_I_BIT]),
    .cpsr_f (cpsr_in[CPSR_F_BIT]),
    .winner (winner)
  );

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cpsr_d  = cpsr_q;
    pc_d    = pc_q;
    dabt_d  = dabt_q | data_abort;
    pabt_d  = pabt_q | prefetch_abort;
    und_d   = und_q  | undef_instr;
    swi_d   = swi_q  | swi_instr;
    case (state_q)
      IDLE: begin
        if (instr_boundary && winner != EXC_NONE) begin
          state_d = ENTRY;
          type_d  = winner;
          cpsr_d  = cpsr_in;
          pc_d    = pc_in;
          case (winner)
            EXC_DABT:  dabt_d = 1'b0;
            EXC_PABT:  pabt_d = 1'b0;
            EXC_UNDEF: und_d  = 1'b0;
            EXC_SWI:   swi_d  = 1'b0;
            default: ;
          endcase
        end
      end
      ENTRY:   state_d = BRANCH;
      BRANCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= EXC_NONE;
      cpsr_q  <= 32'h0;
      pc_q    <= 32'h0;
      dabt_q  <= 1'b0;
      pabt_q  <= 1'b0;
      und_q   <= 1'b0;
      swi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cpsr_q  <= cpsr_d;
      pc_q    <= pc_d;
      dabt_q  <= dabt_d;
      pabt_q  <= pabt_d;
      und_q   <= und_d;
      swi_q   <= swi_d;
    end
  end

  // Thumb undef/SWI return to the next halfword; dabt returns past the pipeline.
  always_comb begin
    lr_off = 32'd4;
    if (type_q == EXC_DABT)
      lr_off = 32'd8;
    else if ((type_q == EXC_UNDEF || type_q == EXC_SWI) && cpsr_q[CPSR_T_BIT])
      lr_off = 32'd2;
    cpsr_new             = cpsr_q;
    cpsr_new[4:0]        = exc_target_mode(type_q);
    cpsr_new[CPSR_I_BIT] = 1'b1;
    cpsr_new[CPSR_T_BIT] = 1'b0;
    if (type_q == EXC_FIQ) cpsr_new[CPSR_F_BIT] = 1'b1;
  end

  always_comb begin
    exc_active = 1'b0;
    exc_mode   = 5'h0;
    spsr_we    = 1'b0;
    spsr_wdata = 32'h0;
    lr_we      = 1'b0;
    lr_wdata   = 32'h0;
    cpsr_we    = 1'b0;
    cpsr_wdata = 32'h0;
    pc_we      = 1'b0;
    pc_wdata   = 32'h0;
    exc_done   = 1'b0;
    case (state_q)
      ENTRY: begin
        exc_active = 1'b1;
        exc_mode   = exc_target_mode(type_q);
        spsr_we    = 1'b1;
        spsr_wdata = cpsr_q;
        lr_we      = 1'b1;
        lr_wdata   = pc_q + lr_off;
      end
      BRANCH: begin
        exc_active = 1'b1;
        exc_mode   = exc_target_mode(type_q);
        cpsr_we    = 1'b1;
        cpsr_wdata = cpsr_new;
        pc_we      = 1'b1;
        pc_wdata   = VECTOR_BASE + exc_vec_offset(type_q);
        exc_done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm7tdmi_exception_ctrl.sv
// Scoreboard bench for the exception entry sequencer: expected entries are queued
// at stimulus time and checked by a negedge monitor as ENTRY/BRANCH appear.
module tb_arm7tdmi_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fiq, irq, data_abort, prefetch_abort, undef_instr, swi_instr;
  logic        instr_boundary;
  logic [31:0] cpsr_in, pc_in;
  logic        exc_active, spsr_we, lr_we, cpsr_we, pc_we, exc_done;
  logic [4:0]  exc_mode;
  logic [31:0] spsr_wdata, lr_wdata, cpsr_wdata, pc_wdata;

  typedef struct packed {
    logic [31:0] spsr;
    logic [31:0] lr;
    logic [4:0]  mode;
    logic [31:0] cpsr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arm7tdmi_exception_ctrl #(.VECTOR_BASE(32'h0)) dut (
    .clk(clk), .rst(rst), .fiq(fiq), .irq(irq),
    .data_abort(data_abort), .prefetch_abort(prefetch_abort),
    .undef_instr(undef_instr), .swi_instr(swi_instr),
    .instr_boundary(instr_boundary), .cpsr_in(cpsr_in), .pc_in(pc_in),
    .exc_active(exc_active), .exc_mode(exc_mode),
    .spsr_we(spsr_we), .spsr_wdata(spsr_wdata),
    .lr_we(lr_we), .lr_wdata(lr_wdata),
    .cpsr_we(cpsr_we), .cpsr_wdata(cpsr_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .exc_done(exc_done)
  );

  // Monitor: ENTRY cycles check SPSR/LR, BRANCH cycles check CPSR/PC and pop.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (spsr_we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL entry_unexpected: spsr=%h lr=%h mode=%h required no entry", spsr_wdata, lr_wdata, exc_mode);
        end else if ({spsr_wdata, lr_wdata, exc_mode, lr_we, cpsr_we, pc_we, exc_done, exc_active} !==
                     {sb[0].spsr, sb[0].lr, sb[0].mode, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL entry_cycle: got spsr=%h lr=%h mode=%h lr_we=%b cpsr_we=%b pc_we=%b done=%b act=%b required spsr=%h lr=%h mode=%h",
                   spsr_wdata, lr_wdata, exc_mode, lr_we, cpsr_we, pc_we, exc_done, exc_active,
                   sb[0].spsr, sb[0].lr, sb[0].mode);
        end
      end
      if (cpsr_we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL branch_unexpected: cpsr=%h pc=%h required no branch", cpsr_wdata, pc_wdata);
        end else begin
          if ({cpsr_wdata, pc_wdata, exc_mode, exc_done, pc_we, spsr_we, lr_we, exc_active} !==
              {sb[0].cpsr, sb[0].pc, sb[0].mode, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL branch_cycle: got cpsr=%h pc=%h mode=%h done=%b pc_we=%b spsr_we=%b lr_we=%b act=%b required cpsr=%h pc=%h mode=%h",
                     cpsr_wdata, pc_wdata, exc_mode, exc_done, pc_we, spsr_we, lr_we, exc_active,
                     sb[0].cpsr, sb[0].pc, sb[0].mode);
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fiq = 0; irq = 0; data_abort = 0; prefetch_abort = 0;
    undef_instr = 0; swi_instr = 0; instr_boundary = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    cpsr_in = 32'h10; pc_in = 32'h0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({exc_active, exc_mode, spsr_we, spsr_wdata, lr_we, lr_wdata, cpsr_we, cpsr_wdata,
         pc_we, pc_wdata, exc_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: act=%b mode=%h spsr_we=%b lr_we=%b cpsr_we=%b pc_we=%b done=%b required all 0",
               exc_active, exc_mode, spsr_we, lr_we, cpsr_we, pc_we, exc_done);
    end
    cyc();
  endtask

  task automatic test_irq();
    cpsr_in = 32'h10; pc_in = 32'h100; irq = 1; instr_boundary = 1;
    sb.push_back('{spsr: 32'h10, lr: 32'h104, mode: 5'h12, cpsr: 32'h92, pc: 32'h18});
    cyc();
    irq = 0; instr_boundary = 0; cpsr_in = 32'h92;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL irq_drain: pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_irq_masked();
    logic seen;
    seen = 0;
    cpsr_in = 32'h90; pc_in = 32'h140; irq = 1; instr_boundary = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (exc_active || spsr_we || lr_we || cpsr_we || pc_we) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: activity=%b required 0", seen);
    end
    cyc();
    irq = 0; instr_boundary = 0;
  endtask

  task automatic test_fiq_irq();
    cpsr_in = 32'h10; pc_in = 32'h400; fiq = 1; irq = 1; instr_boundary = 1;
    sb.push_back('{spsr: 32'h10, lr: 32'h404, mode: 5'h11, cpsr: 32'hD1, pc: 32'h1C});
    cyc();
    cpsr_in = 32'hD1;
    for (int i = 0; i < 12; i++) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fiq_irq_drain: pending=%0d required 0", sb.size());
      sb.delete();
    end
    fiq = 0; irq = 0; instr_boundary = 0; cpsr_in = 32'h10;
    cyc();
  endtask

  task automatic test_dabt_fiq();
    cpsr_in = 32'h10; pc_in = 32'h200; data_abort = 1; fiq = 1; instr_boundary = 1;
    sb.push_back('{spsr: 32'h10, lr: 32'h208, mode: 5'h17, cpsr: 32'h97, pc: 32'h10});
    sb.push_back('{spsr: 32'h97, lr: 32'h504, mode: 5'h11, cpsr: 32'hD1, pc: 32'h1C});
    cyc();
    data_abort = 0; cpsr_in = 32'h97; pc_in = 32'h500;
    cyc(); cyc(); cyc();
    fiq = 0; instr_boundary = 0; cpsr_in = 32'hD1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL dabt_fiq_drain: pending=%0d required 0", sb.size());
      sb.delete();
    end
    cpsr_in = 32'h10;
  endtask

  task automatic test_swi_thumb();
    cpsr_in = 32'h30; pc_in = 32'h300; swi_instr = 1; instr_boundary = 1;
    sb.push_back('{spsr: 32'h30, lr: 32'h302, mode: 5'h13, cpsr: 32'h93, pc: 32'h08});
    cyc();
    swi_instr = 0; instr_boundary = 0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL swi_thumb_drain: pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    cpsr_in = 32'h10; pc_in = 32'h600; undef_instr = 1; swi_instr = 1; instr_boundary = 0;
    cyc();
    undef_instr = 0; swi_instr = 0;
    cyc(); cyc();
    sb.push_back('{spsr: 32'h10, lr: 32'h604, mode: 5'h1B, cpsr: 32'h9B, pc: 32'h04});
    sb.push_back('{spsr: 32'h9B, lr: 32'h604, mode: 5'h13, cpsr: 32'h93, pc: 32'h08});
    instr_boundary = 1;
    cyc();
    cpsr_in = 32'h9B;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    instr_boundary = 0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL undef_swi_drain: pending=%0d required 0", sb.size());
      sb.delete();
    end
    cpsr_in = 32'h10;
    cyc(); cyc();
  endtask

  task automatic test_rst_mid();
    logic seen;
    cpsr_in = 32'h10; pc_in = 32'h700; data_abort = 1; instr_boundary = 1;
    sb.push_back('{spsr: 32'h10, lr: 32'h708, mode: 5'h17, cpsr: 32'h97, pc: 32'h10});
    cyc();
    data_abort = 0; instr_boundary = 0; rst = 1;
    cyc();
    @(negedge clk);
    checks++;
    if ({exc_active, exc_mode, spsr_we, spsr_wdata, lr_we, lr_wdata, cpsr_we, cpsr_wdata,
         pc_we, pc_wdata, exc_done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: act=%b mode=%h spsr_we=%b lr_we=%b cpsr_we=%b pc_we=%b pc=%h required all 0",
               exc_active, exc_mode, spsr_we, lr_we, cpsr_we, pc_we, pc_wdata);
    end
    sb.delete();
    // a pending prefetch abort latched before reset must be discarded
    cyc();
    rst = 0; prefetch_abort = 1;
    cyc();
    prefetch_abort = 0; rst = 1;
    cyc();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (exc_active || pc_we) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_quiet: activity=%b required 0", seen);
    end
    seen = 0;
    instr_boundary = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (exc_active || pc_we) seen = 1;
    end
    instr_boundary = 0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_clears_pending: activity=%b required 0", seen);
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    cpsr_in = 32'h10; pc_in = 32'h0;
    test_reset();
    test_irq();
    test_irq_masked();
    test_fiq_irq();
    test_dabt_fiq();
    test_swi_thumb();
    test_back_to_back();
    test_rst_mid();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded required finish");
    $fatal(1);
  end

endmodule

// File: doc/arm7tdmi_exception_ctrl.md
# arm7tdmi_exception_ctrl

Exception entry sequencer for the ARM7TDMI core. It latches and prioritises FIQ, IRQ, data/prefetch abort, undefined-instruction and SWI requests. At an instruction boundary it drives the register file and CPSR/SPSR write ports through the architectural entry sequence: save CPSR, set banked LR, switch mode and mask bits, then redirect the PC to the vector. It sits beside the decode/execute control and owns the exception-entry write ports while active.

## Interface
- VECTOR_BASE, 32'h0000_0000, base address added to every vector offset
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- fiq, irq  in  1 each  level interrupt requests, already synchronised
- data_abort, prefetch_abort, undef_instr, swi_instr  in  1 each  single-cycle pulses from execute
- instr_boundary  in  1  core can accept an exception this cycle
- cpsr_in  in  32  current CPSR
- pc_in  in  32  address of faulting instruction (sync) or of next instruction to execute (IRQ/FIQ)
- exc_active  out  1  sequence in progress; core stalls/flushes
- exc_mode  out  5  target processor_mode_t, selects banked LR/SPSR
- spsr_we / spsr_wdata  out  1 / 32  SPSR write of target mode
- lr_we / lr_wdata  out  1 / 32  banked R14 write
- cpsr_we / cpsr_wdata  out  1 / 32  CPSR write
- pc_we / pc_wdata  out  1 / 32  PC redirect
- exc_done  out  1  one-cycle pulse on final entry cycle

## Operation
- Sync pulses set sticky pending flags. A flag clears only when its exception is taken or on rst.
- IRQ/FIQ are level-sensitive, not latched. They are eligible only when cpsr_in I (bit 7) / F (bit 6) is 0.
- Effective pending = flags OR same-cycle pulses.
- Priority: data abort > FIQ > IRQ > prefetch abort > undef > SWI.
- Exception type to mode / vector offset:
  - dabt: ABORT / 0x10
  - FIQ: FIQ / 0x1C
  - IRQ: IRQ / 0x18
  - pabt: ABORT / 0x0C
  - undef: UNDEFINED / 0x04
  - SWI: SUPERVISOR / 0x08
- LR offset:
  - dabt: +8
  - undef/SWI with cpsr_in T=1: +2
  - all others: +4
  - 32-bit add, wraps modulo 2^32.
- FSM states IDLE, ENTRY, BRANCH.
  - IDLE → ENTRY when instr_boundary=1 and any eligible request exists. The winning type, cpsr_in and pc_in are captured in that same cycle, and the winner's flag is cleared.
  - ENTRY: spsr_we=1 with spsr_wdata = captured CPSR; lr_we=1 with lr_wdata = captured pc + offset. → BRANCH unconditionally.
  - BRANCH:
    - cpsr_we=1; cpsr_wdata = captured CPSR with [4:0] = target mode, I=1, T=0, F=1 only for FIQ, flags [31:28] unchanged.
    - pc_we=1; pc_wdata = VECTOR_BASE + offset.
    - exc_done=1. → IDLE.
- exc_active=1 in ENTRY and BRANCH. exc_mode is valid in those states and 0 in IDLE.
- Requests arriving during ENTRY/BRANCH are latched; they are evaluated again in IDLE against the updated cpsr_in.
- Undef and SWI are never taken together; undef wins if both are present.

## Timing
- Reset: state IDLE, all pending flags 0, every output 0.
- Decision cycle N (IDLE, boundary high) → ENTRY in N+1 → BRANCH in N+2 → earliest next ENTRY in N+4. The core must present the updated cpsr_in by N+3.
- Outputs are Moore, decoded from state and captured registers; no combinational input-to-output path.
- rst mid-sequence: next cycle is IDLE and every output is 0. A partially written SPSR/LR is acceptable; no BRANCH occurs.
- instr_boundary is ignored outside IDLE.

## Structure
- arm7tdmi_pkg additions:
  - exc_type_t enum (EXC_NONE, EXC_DABT, EXC_FIQ, EXC_IRQ, EXC_PABT, EXC_UNDEF, EXC_SWI)
  - exc_state_t (IDLE, ENTRY, BRANCH)
  - VEC_* offset parameters
- Reuses processor_mode_t and CPSR_*_BIT from arm7tdmi_pkg.
- One combinational sub-module, arm7tdmi_exc_prio_enc: pending vector + cpsr mask bits → winning exc_type_t.

## Test plan
- IRQ, cpsr_in=0x10, pc_in=0x100, boundary:
  - ENTRY: spsr_wdata=0x10, lr_wdata=0x104, exc_mode=0x12
  - BRANCH: cpsr_wdata=0x92, pc_wdata=0x18, exc_done=1
- IRQ with cpsr_in=0x90 held 10 cycles → exc_active stays 0, no write enables.
- FIQ+IRQ together, cpsr_in=0x10 → pc_wdata=0x1C, cpsr_wdata=0xD1. With cpsr_in then 0xD1, IRQ is never taken.
- data_abort pulse and FIQ in the same cycle, pc_in=0x200, cpsr 0x10 → lr_wdata=0x208, pc_wdata=0x10, cpsr_wdata=0x97. Next IDLE with cpsr_in=0x97 → FIQ taken (pc_wdata=0x1C).
- SWI in Thumb, cpsr_in=0x30, pc_in=0x300 → lr_wdata=0x302, cpsr_wdata=0x93, pc_wdata=0x08.
- rst asserted during ENTRY of a dabt → next cycle all outputs 0, no pc_we. After rst release with no stimulus, exc_active stays 0.
